// File: rtl/touch_pkg.sv
// Shared types and helpers for the on-screen touch button decoder.
package touch_pkg;

   localparam int unsigned X_W     = 11;
   localparam int unsigned Y_W     = 10;
   localparam int unsigned MAX_BTN = 16;

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      DEB_RELEASE
   } btn_state_e;

   // Extract one button's X edge from a packed region vector.
   function automatic logic [X_W-1:0] unpack_x(input logic [MAX_BTN*X_W-1:0] v,
                                                input int unsigned idx);
      return v[idx*X_W +: X_W];
   endfunction

   // Extract one button's Y edge from a packed region vector.
   function automatic logic [Y_W-1:0] unpack_y(input logic [MAX_BTN*Y_W-1:0] v,
                                                input int unsigned idx);
      return v[idx*Y_W +: Y_W];
   endfunction

endpackage

// File: rtl/touch_button_array_if.sv
// Touch coordinate input and per-button event outputs of the button decoder.
interface touch_button_array_if #(
   parameter int unsigned NUM_BTN = 2
);
   import touch_pkg::*;

   localparam int unsigned CODE_W = $clog2(NUM_BTN) + 1;

   logic               enable;
   logic [X_W-1:0]     gr_x;
   logic [Y_W-1:0]     gr_y;
   logic [NUM_BTN-1:0] btn_held;
   logic [NUM_BTN-1:0] btn_press;
   logic [NUM_BTN-1:0] btn_release;
   logic [NUM_BTN-1:0] btn_repeat;
   logic               btn_any;
   logic [CODE_W-1:0]  btn_code;

   modport master (
      output enable, gr_x, gr_y,
      input  btn_held, btn_press, btn_release, btn_repeat, btn_any, btn_code
   );

   modport slave (
      input  enable, gr_x, gr_y,
      output btn_held, btn_press, btn_release, btn_repeat, btn_any, btn_code
   );

endinterface

// File: rtl/touch_button_fsm.sv
// Per-button debounce / hold / auto-repeat state machine with registered event pulses.
module touch_button_fsm
   import touch_pkg::*;
#(
   parameter int unsigned DEBOUNCE      = 4,
   parameter int unsigned HOLD_CYCLES   = 50,
   parameter int unsigned REPEAT_CYCLES = 10,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_hit,
   output logic o_held,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int unsigned CNT_MAX = (DEBOUNCE > HOLD_CYCLES) ? DEBOUNCE : HOLD_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_RELOAD =
      CNT_W'((HOLD_CYCLES > REPEAT_CYCLES) ? (HOLD_CYCLES - REPEAT_CYCLES) : 0);
   localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

   btn_state_e       r_state;
   logic [CNT_W-1:0] r_dcnt;
   logic [CNT_W-1:0] r_rcnt;
   logic             r_held;
   logic             r_press;
   logic             r_release;
   logic             r_repeat;

   // Debounce counter confirms a change of hit level; repeat counter runs only while settled in HELD.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_dcnt    <= '0;
         r_rcnt    <= '0;
         r_held    <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_hit) begin
                  if (DEBOUNCE == 1) begin
                     r_state <= HELD;
                     r_held  <= 1'b1;
                     r_press <= 1'b1;
                     r_rcnt  <= '0;
                  end else begin
                     r_state <= DEB_PRESS;
                     r_dcnt  <= CNT_W'(1);
                  end
               end
            end
            DEB_PRESS: begin
               if (!i_hit) begin
                  r_state <= IDLE;
                  r_dcnt  <= '0;
               end else if (r_dcnt >= DEB_LAST) begin
                  r_state <= HELD;
                  r_held  <= 1'b1;
                  r_press <= 1'b1;
                  r_dcnt  <= '0;
                  r_rcnt  <= '0;
               end else if (r_dcnt != CNT_SAT) begin
                  r_dcnt <= r_dcnt + CNT_W'(1);
               end
            end
            HELD: begin
               if (!i_hit) begin
                  if (DEBOUNCE == 1) begin
                     r_state   <= IDLE;
                     r_held    <= 1'b0;
                     r_release <= 1'b1;
                     r_rcnt    <= '0;
                  end else begin
                     r_state <= DEB_RELEASE;
                     r_dcnt  <= CNT_W'(1);
                  end
               end else if (REPEAT_EN && (r_rcnt == HOLD_LAST)) begin
                  r_repeat <= 1'b1;
                  r_rcnt   <= RPT_RELOAD;
               end else if (r_rcnt != CNT_SAT) begin
                  r_rcnt <= r_rcnt + CNT_W'(1);
               end
            end
            DEB_RELEASE: begin
               if (i_hit) begin
                  r_state <= HELD;
                  r_dcnt  <= '0;
               end else if (r_dcnt >= DEB_LAST) begin
                  r_state   <= IDLE;
                  r_held    <= 1'b0;
                  r_release <= 1'b1;
                  r_dcnt    <= '0;
                  r_rcnt    <= '0;
               end else if (r_dcnt != CNT_SAT) begin
                  r_dcnt <= r_dcnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_held  <= 1'b0;
               r_dcnt  <= '0;
               r_rcnt  <= '0;
            end
         endcase
      end
   end

   assign o_held    = r_held;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/touch_button_array.sv
// NUM_BTN rectangular touch regions: registered priority hit test feeding one debounce FSM per button.
module touch_button_array
   import touch_pkg::*;
#(
   parameter int unsigned              NUM_BTN       = 2,
   parameter logic [NUM_BTN*X_W-1:0]   X_LO          = {11'd406, 11'd206},
   parameter logic [NUM_BTN*X_W-1:0]   X_HI          = {11'd495, 11'd295},
   parameter logic [NUM_BTN*Y_W-1:0]   Y_LO          = {10'd301, 10'd301},
   parameter logic [NUM_BTN*Y_W-1:0]   Y_HI          = {10'd380, 10'd380},
   parameter int unsigned              DEBOUNCE      = 4,
   parameter int unsigned              HOLD_CYCLES   = 50,
   parameter int unsigned              REPEAT_CYCLES = 10,
   parameter bit                       REPEAT_EN     = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   touch_button_array_if.slave  bus
);

   localparam int unsigned CODE_W = $clog2(NUM_BTN) + 1;
   localparam logic [MAX_BTN*X_W-1:0] X_LO_EXT = (MAX_BTN*X_W)'(X_LO);
   localparam logic [MAX_BTN*X_W-1:0] X_HI_EXT = (MAX_BTN*X_W)'(X_HI);
   localparam logic [MAX_BTN*Y_W-1:0] Y_LO_EXT = (MAX_BTN*Y_W)'(Y_LO);
   localparam logic [MAX_BTN*Y_W-1:0] Y_HI_EXT = (MAX_BTN*Y_W)'(Y_HI);

   logic [NUM_BTN-1:0] w_hit_raw;
   logic [NUM_BTN-1:0] w_hit_pri;
   logic [NUM_BTN-1:0] r_hit_q;
   logic [NUM_BTN-1:0] w_held;
   logic [NUM_BTN-1:0] w_press;
   logic [NUM_BTN-1:0] w_release;
   logic [NUM_BTN-1:0] w_repeat;
   logic [CODE_W-1:0]  w_code;

   // Inclusive unsigned rectangle test per button.
   always_comb begin
      w_hit_raw = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         w_hit_raw[i] = bus.enable &&
                        (bus.gr_x >= unpack_x(X_LO_EXT, i)) && (bus.gr_x <= unpack_x(X_HI_EXT, i)) &&
                        (bus.gr_y >= unpack_y(Y_LO_EXT, i)) && (bus.gr_y <= unpack_y(Y_HI_EXT, i));
      end
   end

   // Isolate the lowest set bit so overlapping regions resolve to the lowest index.
   assign w_hit_pri = w_hit_raw & (~w_hit_raw + NUM_BTN'(1));

   always_ff @(posedge clk) begin
      if (reset) r_hit_q <= '0;
      else       r_hit_q <= w_hit_pri;
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      touch_button_fsm #(
         .DEBOUNCE      (DEBOUNCE),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_EN)
      ) u_fsm (
         .clk       (clk),
         .reset     (reset),
         .i_hit     (r_hit_q[g]),
         .o_held    (w_held[g]),
         .o_press   (w_press[g]),
         .o_release (w_release[g]),
         .o_repeat  (w_repeat[g])
      );
   end

   // Lowest held index wins; all-ones when nothing is held.
   always_comb begin
      w_code = '1;
      for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
         if (w_held[i]) w_code = CODE_W'(i);
      end
   end

   assign bus.btn_held    = w_held;
   assign bus.btn_press   = w_press;
   assign bus.btn_release = w_release;
   assign bus.btn_repeat  = w_repeat;
   assign bus.btn_any     = |w_held;
   assign bus.btn_code    = w_code;

endmodule

// File: tb/tb_touch_button_array.sv
// Directed bench for touch_button_array: default regions plus an overlapping-region instance.
module tb_touch_button_array;
   import touch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   touch_button_array_if #(.NUM_BTN(2)) if0 ();
   touch_button_array_if #(.NUM_BTN(2)) if1 ();

   touch_button_array u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   // Button 0 spans x 206..320, button 1 spans x 280..400: they overlap on 280..320.
   touch_button_array #(
      .NUM_BTN (2),
      .X_LO    ({11'd280, 11'd206}),
      .X_HI    ({11'd400, 11'd320}),
      .Y_LO    ({10'd301, 10'd301}),
      .Y_HI    ({10'd380, 10'd380})
   ) u_dut_ovl (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   int pc [2][2];
   int rc [2][2];
   int rp [2][2];
   int first_press [2];
   int first_rel   [2];
   int first_rep   [2];
   int last_rep    [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 2; b++) begin
            pc[d][b] = 0;
            rc[d][b] = 0;
            rp[d][b] = 0;
         end
         first_press[d] = 0;
         first_rel[d]   = 0;
         first_rep[d]   = 0;
         last_rep[d]    = 0;
      end
   endtask

   // One clock edge, then sample outputs 1 time unit later and tally event pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int b = 0; b < 2; b++) begin
         if (if0.btn_press[b]) begin
            pc[0][b]++;
            if (first_press[b] == 0) first_press[b] = cyc;
         end
         if (if0.btn_release[b]) begin
            rc[0][b]++;
            if (first_rel[b] == 0) first_rel[b] = cyc;
         end
         if (if0.btn_repeat[b]) begin
            rp[0][b]++;
            if (first_rep[b] == 0) first_rep[b] = cyc;
            last_rep[b] = cyc;
         end
         if (if1.btn_press[b])   pc[1][b]++;
         if (if1.btn_release[b]) rc[1][b]++;
         if (if1.btn_repeat[b])  rp[1][b]++;
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic set0(input logic en, input int x, input int y);
      if0.enable = en;
      if0.gr_x   = 11'(x);
      if0.gr_y   = 10'(y);
   endtask

   task automatic set1(input logic en, input int x, input int y);
      if1.enable = en;
      if1.gr_x   = 11'(x);
      if1.gr_y   = 10'(y);
   endtask

   int bx [4] = '{205, 296, 250, 250};
   int by [4] = '{340, 340, 300, 381};

   initial begin
      reset = 1'b1;
      set0(1'b1, 250, 340);
      set1(1'b0, 0, 0);
      clr();

      // Reset held with a valid touch present
      run(3);
      check("rst_held",    32'(if0.btn_held),    0);
      check("rst_press",   32'(if0.btn_press),   0);
      check("rst_release", 32'(if0.btn_release), 0);
      check("rst_repeat",  32'(if0.btn_repeat),  0);
      check("rst_any",     32'(if0.btn_any),     0);
      check("rst_code",    32'(if0.btn_code),    3);

      // Press latency: first sample is edge 1, press visible after edge 5
      reset = 1'b0;
      clr();
      run(4);
      check("t1_no_early_press", 32'(pc[0][0]), 0);
      run(1);
      check("t1_press_cyc",  32'(first_press[0]), 5);
      check("t1_press_now",  32'(if0.btn_press),  1);
      run(1);
      check("t1_press_1cyc", 32'(if0.btn_press),  0);
      check("t1_held",       32'(if0.btn_held),   1);
      check("t1_code",       32'(if0.btn_code),   0);
      check("t1_any",        32'(if0.btn_any),    1);

      // Reset mid-press: no release pulse afterwards
      set0(1'b0, 250, 340);
      reset = 1'b1;
      clr();
      run(2);
      reset = 1'b0;
      run(10);
      check("rstmid_no_release", 32'(rc[0][0]), 0);
      check("rstmid_held",       32'(if0.btn_held), 0);

      // Short touch (2 cycles) never confirms a press
      clr();
      set0(1'b1, 250, 340);
      run(2);
      set0(1'b0, 250, 340);
      run(10);
      check("t2_no_press", 32'(pc[0][0]), 0);
      check("t2_held",     32'(if0.btn_held), 0);

      // Long hold on button 1: repeats at press+50 then every 10, release 5 edges after last hit
      clr();
      set0(1'b1, 450, 340);
      run(100);
      set0(1'b0, 450, 340);
      run(10);
      check("t3_press_cyc",    32'(first_press[1]), 5);
      check("t3_press_cnt",    32'(pc[0][1]),       1);
      check("t3_rep_cnt",      32'(rp[0][1]),       5);
      check("t3_first_rep",    32'(first_rep[1]),   55);
      check("t3_last_rep",     32'(last_rep[1]),    95);
      check("t3_rel_cyc",      32'(first_rel[1]),   105);
      check("t3_rel_cnt",      32'(rc[0][1]),       1);
      check("t3_btn0_quiet",   32'(pc[0][0]),       0);
      check("t3_held_end",     32'(if0.btn_held),   0);

      // Release bounce at the inclusive top-left corner of button 0
      clr();
      set0(1'b1, 206, 301);
      run(8);
      check("t4_held_pre", 32'(if0.btn_held), 1);
      set0(1'b0, 206, 301);
      run(2);
      set0(1'b1, 206, 301);
      run(10);
      check("t4_no_release", 32'(rc[0][0]),      0);
      check("t4_one_press",  32'(pc[0][0]),      1);
      check("t4_held_post",  32'(if0.btn_held),  1);
      set0(1'b0, 0, 0);
      reset = 1'b1;
      run(2);
      reset = 1'b0;

      // Just-outside boundary points never hit
      clr();
      for (int k = 0; k < 4; k++) begin
         set0(1'b1, bx[k], by[k]);
         run(8);
         check($sformatf("t5_out_press_%0d", k), 32'(pc[0][0]),     0);
         check($sformatf("t5_out_held_%0d", k),  32'(if0.btn_held), 0);
      end
      set0(1'b1, 295, 380);
      run(8);
      check("t5_in_press", 32'(pc[0][0]),     1);
      check("t5_in_held",  32'(if0.btn_held), 1);
      set0(1'b0, 0, 0);
      reset = 1'b1;
      run(2);
      reset = 1'b0;

      // Overlap: lowest index wins, then slide into button 1 only
      clr();
      set1(1'b1, 300, 340);
      run(8);
      check("t6_a_press",   32'(pc[1][0]),     1);
      check("t6_b_nopress", 32'(pc[1][1]),     0);
      check("t6_held_a",    32'(if1.btn_held), 1);
      set1(1'b1, 350, 340);
      run(4);
      check("t6_held_mid",  32'(if1.btn_held), 1);
      run(1);
      check("t6_held_b",    32'(if1.btn_held), 2);
      check("t6_code_b",    32'(if1.btn_code), 1);
      run(10);
      check("t6_a_rel_cnt", 32'(rc[1][0]), 1);
      check("t6_b_prs_cnt", 32'(pc[1][1]), 1);
      check("t6_a_prs_cnt", 32'(pc[1][0]), 1);
      check("t6_b_rel_cnt", 32'(rc[1][1]), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
